fmap_serializer: RTL

- Reads the final pooled feature maps (IC channel bitmaps, level-qualified by data_in_ready) at the output of the BNN layer chain.
- Snapshots them and streams them out as W-bit beats on a valid/ready interface toward the host link (UART/SPI bridge).
- Acts as the reader at the far end of the layer data_in_ready/img level protocol.
- Frees the upstream pooling stage as soon as the snapshot is taken.

---
 rtl/bnn_pkg.sv | 19 +
 rtl/fmap_byte_select.sv | 23 ++
 rtl/fmap_serializer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared BNN layer-chain types and constants used by the feature-map
// serializer and the pooling stage.
package bnn_pkg;

    localparam int IMG_SIZE_DEF = 14;
    localparam int IC_DEF       = 10;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        SEND,
        DONE
    } fmap_state_t;

    function automatic int bytes_per_ch(input int size, input int w);
        return (size * size + w - 1) / w;
    endfunction

endpackage

// File: rtl/fmap_byte_select.sv
// Picks one W-bit beat out of a channel bitmap; pixels past the end of the
// bitmap read as zero. Shared with the debug readback path.
module fmap_byte_select
    import bnn_pkg::*;
#(
    parameter int IMG_SIZE = IMG_SIZE_DEF,
    parameter int W        = 8
) (
    input  logic [IMG_SIZE*IMG_SIZE-1:0]                                 chan_i,
    input  logic [((bytes_per_ch(IMG_SIZE, W) > 1) ?
                   $clog2(bytes_per_ch(IMG_SIZE, W)) : 1)-1:0]           byte_idx_i,
    output logic [W-1:0]                                                 data_o
);

    localparam int BPC = bytes_per_ch(IMG_SIZE, W);
    localparam int PW  = BPC * W;

    logic [PW-1:0] padded;

    assign padded = PW'(chan_i);
    assign data_o = padded[byte_idx_i*W +: W];

endmodule

// File: rtl/fmap_serializer.sv
// Snapshots the final pooled feature maps and streams them as W-bit beats.
// Define FMAP_SERIALIZER_CH_HEADER_EN to prefix each channel with an index beat.
module fmap_serializer
    import bnn_pkg::*;
#(
    parameter int IMG_SIZE = IMG_SIZE_DEF,
    parameter int IC       = IC_DEF,
    parameter int W        = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         data_in_ready,
    input  logic [IMG_SIZE*IMG_SIZE-1:0] img_in [0:IC-1],
    output logic [W-1:0]                 out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_ch_last,
    output logic                         out_last,
    output logic                         busy,
    output logic                         frame_done
);

    localparam int NPIX = IMG_SIZE * IMG_SIZE;
    localparam int BPC  = bytes_per_ch(IMG_SIZE, W);
    localparam int CW   = (IC > 1) ? $clog2(IC) : 1;
    localparam int BW   = (BPC > 1) ? $clog2(BPC) : 1;

`ifdef FMAP_SERIALIZER_CH_HEADER_EN
    localparam fmap_state_t CH_START = HDR;
    if (W < $clog2(IC)) begin : g_hdr_width_chk
        $error("fmap_serializer: W too narrow to carry channel index");
    end
`else
    localparam fmap_state_t CH_START = SEND;
`endif

    fmap_state_t      state_q, state_d;
    logic [CW-1:0]    ch_q, ch_d;
    logic [BW-1:0]    byte_q, byte_d;
    logic             armed_q, armed_d;
    logic             load;
    logic             last_byte, last_ch;
    logic [W-1:0]     sel_data;
    logic [NPIX-1:0]  snap_q [0:IC-1];

    assign last_byte = (byte_q == BW'(BPC - 1));
    assign last_ch   = (ch_q == CW'(IC - 1));

    fmap_byte_select #(
        .IMG_SIZE (IMG_SIZE),
        .W        (W)
    ) u_sel (
        .chan_i     (snap_q[ch_q]),
        .byte_idx_i (byte_q),
        .data_o     (sel_data)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        byte_d  = byte_q;
        armed_d = armed_q;
        load    = 1'b0;
        if (!data_in_ready) armed_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (data_in_ready && armed_q) begin
                    load    = 1'b1;
                    ch_d    = '0;
                    byte_d  = '0;
                    armed_d = 1'b0;
                    state_d = CH_START;
                end
            end
            HDR: begin
                if (out_ready) state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (last_byte) begin
                        byte_d = '0;
                        if (last_ch) begin
                            state_d = DONE;
                        end else begin
                            ch_d    = ch_q + 1'b1;
                            state_d = CH_START;
                        end
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!data_in_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode from registered state only; out_ready never reaches them.
    always_comb begin
        out_valid   = (state_q == SEND) || (state_q == HDR);
        busy        = out_valid;
        frame_done  = (state_q == DONE);
        out_data    = '0;
        out_ch_last = 1'b0;
        out_last    = 1'b0;
        if (state_q == SEND) begin
            out_data    = sel_data;
            out_ch_last = last_byte;
            out_last    = last_byte && last_ch;
        end else if (state_q == HDR) begin
            out_data = W'(ch_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            byte_q  <= '0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            byte_q  <= byte_d;
            armed_q <= armed_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) snap_q <= img_in;
    end

endmodule
